muldiv_engine: RTL



---
 rtl/muldiv_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_engine.sv
// muldiv_engine
//   Iterative signed multiply / divide unit between the A/B operand registers
//   and the Hi/Lo registers of the multicycle MIPS datapath.
//   MULT: radix-2 Booth, one bit per cycle, 64-bit signed product.
//   DIV : restoring division on magnitudes, then a sign-fix cycle.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low; clears all state and outputs
//   start     request pulse, accepted only in IDLE or DONE
//   op        0 = MULT, 1 = DIV (sampled with start)
//   a, b      operands (sampled with start)
//   busy      high in MULT, DIV, FIX
//   done      one-cycle completion pulse
//   div_zero  DIV requested with b == 0; holds until next accepted start
//   high      MULT: product upper half, DIV: remainder
//   low       MULT: product lower half, DIV: quotient
//
// state | meaning
// IDLE  | waiting for start
// MULT  | Booth iterations
// DIV   | restoring-division iterations
// FIX   | apply quotient / remainder signs, write outputs
// DONE  | done pulse; start here begins the next op with no gap
module muldiv_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  // ph is one bit wider than the operand so that subtracting the most
  // negative multiplicand cannot overflow the partial product.
  // In DIV, ph[WIDTH-1:0] holds the partial remainder and pl the quotient.
  logic [WIDTH:0]   ph;
  logic [WIDTH-1:0] pl;
  logic             qm1;
  logic [WIDTH-1:0] m_reg;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mult_ph_nx;
  logic [WIDTH-1:0] mult_pl_nx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_r_nx;
  logic [WIDTH-1:0] div_q_nx;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign busy = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
  assign done = (state == S_DONE);

  // abs of the most negative value stays 2^(WIDTH-1) as an unsigned magnitude
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  always_comb begin
    m_ext = {m_reg[WIDTH-1], m_reg};
    case ({pl[0], qm1})
      2'b10:   booth_sum = ph - m_ext;
      2'b01:   booth_sum = ph + m_ext;
      default: booth_sum = ph;
    endcase
    mult_ph_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mult_pl_nx = {booth_sum[0], pl[WIDTH-1:1]};
  end

  // Partial remainder is always below the divisor magnitude, so the shifted
  // value fits in WIDTH bits; the extra bit only carries the trial sign.
  always_comb begin
    div_shift = {ph[WIDTH-1:0], pl[WIDTH-1]};
    div_trial = div_shift - {1'b0, m_reg};
    if (!div_trial[WIDTH]) begin
      div_r_nx = div_trial[WIDTH-1:0];
      div_q_nx = {pl[WIDTH-2:0], 1'b1};
    end else begin
      div_r_nx = div_shift[WIDTH-1:0];
      div_q_nx = {pl[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ph       <= '0;
      pl       <= '0;
      qm1      <= 1'b0;
      m_reg    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      high     <= '0;
      low      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            div_zero <= 1'b0;
            cnt      <= CNT_LOAD;
            if (!op) begin
              m_reg <= a;
              ph    <= '0;
              pl    <= b;
              qm1   <= 1'b0;
              state <= S_MULT;
            end else if (b == '0) begin
              div_zero <= 1'b1;
              state    <= S_DONE;
            end else begin
              m_reg  <= abs_b;
              ph     <= '0;
              pl     <= abs_a;
              qm1    <= 1'b0;
              sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r <= a[WIDTH-1];
              state  <= S_DIV;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MULT: begin
          ph  <= mult_ph_nx;
          pl  <= mult_pl_nx;
          qm1 <= pl[0];
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            high  <= mult_ph_nx[WIDTH-1:0];
            low   <= mult_pl_nx;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          ph  <= {1'b0, div_r_nx};
          pl  <= div_q_nx;
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          low   <= sign_q ? -pl : pl;
          high  <= sign_r ? -ph[WIDTH-1:0] : ph[WIDTH-1:0];
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
